mem_dbus_ctrl: RTL and testbench
================================

Name: mem_dbus_ctrl

Overview:
- Memory-stage data-bus master. Consumes the EXE/MEM pipeline-register outputs (mem_aluop, mem_wd used as effective address, mem_din, mem_exccode) and issues loads/stores on the data bus.
- Formats load data, detects misaligned accesses and raises MEM stall requests while a bus transaction is outstanding.
- Sits between the EXE/MEM register and the MEM/WB register; stallreq_mem feeds the stall controller.

Parameters:
- ADDR_W, 32, data-bus address width
- DATA_W, 32, data-bus data width
- ALUOP_W, 8, aluop field width (matches ALUOP_BUS)

Ports:
- cpu_clk_50M  in  1  system clock
- cpu_rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush (exception commit)
- mem_aluop  in  ALUOP_W  operation in MEM stage
- mem_wd  in  32  effective address for memory ops; ALU result otherwise
- mem_din  in  32  store data
- mem_exccode  in  5  upstream exception code (EXC_NONE = no exception)
- dbus_req  out  1  request valid
- dbus_we  out  1  1 = store
- dbus_be  out  4  byte enables
- dbus_addr  out  32  word-aligned address
- dbus_wdata  out  32  lane-shifted store data
- dbus_addr_ok  in  1  request accepted this cycle
- dbus_data_ok  in  1  response/completion this cycle
- dbus_rdata  in  32  load data, valid with dbus_data_ok
- mem_rdata_o  out  32  formatted load result to MEM/WB
- mem_exccode_o  out  5  merged exception code
- mem_badvaddr  out  32  faulting address (valid when AdEL/AdES)
- stallreq_mem  out  1  hold pipeline at/behind MEM

Behaviour:
- Reset, asynchronous on cpu_rst_n low:
  - state = IDLE; dbus_req = 0, dbus_we = 0, dbus_be = 0; dbus_addr, dbus_wdata = 0.
  - mem_rdata_o = 0; stallreq_mem = 0; mem_exccode_o follows input (EXC_NONE at reset).
- Ops handled: LB, LBU, LH, LHU, LW, SB, SH, SW. Any other aluop → no access; outputs pass through.
- Alignment check, combinational on mem_wd[1:0]:
  - Half access with bit0 = 1, or word access with [1:0] ≠ 0 → LW/LH*/LB* raise AdEL (0x04), stores raise AdES (0x05).
  - mem_badvaddr = mem_wd.
  - No bus request is issued.
- Upstream exception (mem_exccode ≠ EXC_NONE) takes priority: it passes through unchanged and no access is issued.
- Byte enables:
  - Byte: one-hot at addr[1:0].
  - Half: 4'b0011 when addr[1] = 0, else 4'b1100.
  - Word: 4'b1111.
- Store data is replicated across lanes (byte ×4, half ×2).
- Loads:
  - Extract the lane selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Result is registered into mem_rdata_o on dbus_data_ok.
- FSM:
  - IDLE: a valid access (legal op, aligned, no upstream exception, flush = 0) asserts dbus_req with addr/be/we/wdata the same cycle, combinationally from inputs, → REQ. dbus_addr_ok in that same cycle → WAIT directly.
  - REQ: hold dbus_req and all bus fields stable until dbus_addr_ok, → WAIT.
  - WAIT: dbus_req = 0. On dbus_data_ok: capture load data → DONE.
  - DONE: one cycle; stallreq_mem = 0 so the pipeline advances; → IDLE.
  - DRAIN: entered from WAIT on flush. Waits for dbus_data_ok, discards data, → IDLE.
- stallreq_mem:
  - 1 whenever a valid access is present and state ∈ {IDLE-with-new-req, REQ, WAIT}.
  - 1 in DRAIN if a new valid access is present.
  - 0 otherwise.
- Flush:
  - In IDLE or REQ (before addr_ok): drop dbus_req the next edge → IDLE, no transaction.
  - Flush in the same cycle as dbus_addr_ok: the transaction is accepted → DRAIN.
  - In WAIT → DRAIN.
  - In DONE → IDLE, mem_rdata_o unchanged.
- dbus_data_ok and dbus_addr_ok in the same cycle while in REQ:
  - Legal for zero-latency slaves.
  - Treated as addr_ok then data_ok → DONE.
- dbus_data_ok outside WAIT/DRAIN is ignored.
- No more than one outstanding transaction, ever.

Decomposition:
- Shared package/define file:
  - aluop encodings for the 8 memory ops
  - EXC_NONE, EXC_ADEL, EXC_ADES
  - FSM state encoding (3 bits: IDLE, REQ, WAIT, DONE, DRAIN)
- One combinational sub-module, mem_lane_fmt: byte-enable generation, store replication, load extract/extend, misalignment flag.

Test Plan:
- LW at 0x0000_1004, addr_ok after 2 cycles, data_ok 1 cycle later with 0xDEADBEEF:
  - dbus_req high for 3 cycles, be = 4'b1111, addr = 0x1004.
  - stallreq_mem high 4 cycles.
  - mem_rdata_o = 0xDEADBEEF in DONE.
- LB at 0x...03, rdata 0x80112233:
  - be = 4'b1000, mem_rdata_o = 0xFFFFFF80.
  - Repeat with LBU → 0x00000080.
- SH at 0x...02, din 0x0000ABCD:
  - be = 4'b1100, wdata = 0xABCDABCD, dbus_we = 1, no rdata update.
- LW at 0x...01:
  - no dbus_req, mem_exccode_o = 0x04, mem_badvaddr = 0x...01, stallreq_mem = 0.
  - SW at the same address → 0x05.
- Flush while in WAIT:
  - → DRAIN; the next LW presented keeps stallreq_mem = 1 and is not requested until data_ok arrives.
  - The old data is discarded and mem_rdata_o is unchanged.
- Reset mid-WAIT:
  - dbus_req = 0, state IDLE, stallreq_mem = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-bus master: memory aluops,
// exception codes, FSM states and the data-bus request payload.
package mem_dbus_ctrl_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXC_W  = 5;

  localparam logic [OP_W-1:0] OP_LB  = 8'h90;
  localparam logic [OP_W-1:0] OP_LBU = 8'h91;
  localparam logic [OP_W-1:0] OP_LH  = 8'h92;
  localparam logic [OP_W-1:0] OP_LHU = 8'h93;
  localparam logic [OP_W-1:0] OP_LW  = 8'h94;
  localparam logic [OP_W-1:0] OP_SB  = 8'h98;
  localparam logic [OP_W-1:0] OP_SH  = 8'h99;
  localparam logic [OP_W-1:0] OP_SW  = 8'h9A;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'h10;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'h04;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'h05;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  typedef struct packed {
    logic              we;
    logic [3:0]        be;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } dbus_req_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting for memory ops (purely combinational).
//   aluop/addr_lo : operation and low address bits
//   din / rdata   : raw store data / raw bus read data
//   is_mem_c, is_store_c, misaligned_c : op classification and alignment fault
//   be_c, wdata_c : byte enables and lane-replicated store data
//   rdata_fmt_c   : extracted and extended load result
module mem_lane_fmt
  import mem_dbus_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   aluop,
  input  logic [1:0]        addr_lo,
  input  logic [WORD_W-1:0] din,
  input  logic [WORD_W-1:0] rdata,
  output logic              is_mem_c,
  output logic              is_store_c,
  output logic              misaligned_c,
  output logic [3:0]        be_c,
  output logic [WORD_W-1:0] wdata_c,
  output logic [WORD_W-1:0] rdata_fmt_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  assign byte_c = rdata[{addr_lo, 3'b000} +: 8];
  assign half_c = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    is_mem_c     = 1'b1;
    is_store_c   = 1'b0;
    misaligned_c = 1'b0;
    be_c         = 4'b0000;
    wdata_c      = '0;
    rdata_fmt_c  = '0;
    case (aluop)
      OP_LB, OP_LBU, OP_SB: begin
        be_c        = 4'b0001 << addr_lo;
        wdata_c     = {4{din[7:0]}};
        is_store_c  = (aluop == OP_SB);
        rdata_fmt_c = {{24{(aluop == OP_LB) & byte_c[7]}}, byte_c};
      end
      OP_LH, OP_LHU, OP_SH: begin
        misaligned_c = addr_lo[0];
        be_c         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c      = {2{din[15:0]}};
        is_store_c   = (aluop == OP_SH);
        rdata_fmt_c  = {{16{(aluop == OP_LH) & half_c[15]}}, half_c};
      end
      OP_LW, OP_SW: begin
        misaligned_c = (addr_lo != 2'b00);
        be_c         = 4'b1111;
        wdata_c      = din;
        is_store_c   = (aluop == OP_SW);
        rdata_fmt_c  = rdata;
      end
      default: is_mem_c = 1'b0;
    endcase
    // Loads never drive write data onto the bus.
    if (!is_store_c) wdata_c = '0;
  end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus master: issues one load/store at a time, formats load
// data into mem_rdata_o, flags misaligned accesses and stalls the pipeline
// while a transaction is outstanding.
//   cpu_clk_50M, cpu_rst_n : clock, async active-low reset
//   flush                  : pipeline flush
//   mem_aluop/wd/din/exccode : EXE/MEM register contents
//   dbus_*                 : data-bus request (req/we/be/addr/wdata) and
//                            handshake (addr_ok/data_ok/rdata)
//   mem_rdata_o, mem_exccode_o, mem_badvaddr, stallreq_mem : to MEM/WB and stall ctrl
module mem_dbus_ctrl
  import mem_dbus_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ALUOP_W = 8
)(
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst_n,
  input  logic               flush,
  input  logic [ALUOP_W-1:0] mem_aluop,
  input  logic [31:0]        mem_wd,
  input  logic [31:0]        mem_din,
  input  logic [4:0]         mem_exccode,
  output logic               dbus_req,
  output logic               dbus_we,
  output logic [3:0]         dbus_be,
  output logic [ADDR_W-1:0]  dbus_addr,
  output logic [DATA_W-1:0]  dbus_wdata,
  input  logic               dbus_addr_ok,
  input  logic               dbus_data_ok,
  input  logic [DATA_W-1:0]  dbus_rdata,
  output logic [DATA_W-1:0]  mem_rdata_o,
  output logic [4:0]         mem_exccode_o,
  output logic [31:0]        mem_badvaddr,
  output logic               stallreq_mem
);

  state_t            state_q, state_d;
  dbus_req_t         req_c, req_q, bus_c;
  logic              is_mem_c, is_store_c, misaligned_c;
  logic [3:0]        be_c;
  logic [WORD_W-1:0] wdata_c, rdata_fmt_c;
  logic              valid_c, latch_c, capture_c;

  mem_lane_fmt u_fmt (
    .aluop        (mem_aluop),
    .addr_lo      (mem_wd[1:0]),
    .din          (mem_din),
    .rdata        (dbus_rdata),
    .is_mem_c     (is_mem_c),
    .is_store_c   (is_store_c),
    .misaligned_c (misaligned_c),
    .be_c         (be_c),
    .wdata_c      (wdata_c),
    .rdata_fmt_c  (rdata_fmt_c)
  );

  // A legal access; reset is folded in so bus and stall drop asynchronously.
  assign valid_c = cpu_rst_n & is_mem_c & ~misaligned_c & ~flush &
                   (mem_exccode == EXC_NONE);

  always_comb begin
    req_c.we    = is_store_c;
    req_c.be    = be_c;
    req_c.addr  = {mem_wd[31:2], 2'b00};
    req_c.wdata = wdata_c;
  end

  // Exception merge: upstream code wins over alignment faults.
  always_comb begin
    mem_exccode_o = EXC_NONE;
    if (mem_exccode != EXC_NONE)      mem_exccode_o = mem_exccode;
    else if (is_mem_c & misaligned_c) mem_exccode_o = is_store_c ? EXC_ADES : EXC_ADEL;
  end

  assign mem_badvaddr = mem_wd;

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      mem_rdata_o <= '0;
    end else begin
      state_q <= state_d;
      if (latch_c) req_q <= req_c;
      if (capture_c && !is_store_c) mem_rdata_o <= DATA_W'(rdata_fmt_c);
    end
  end

  // Next state, bus drive and stall request.
  always_comb begin
    state_d      = state_q;
    bus_c        = '0;
    dbus_req     = 1'b0;
    stallreq_mem = 1'b0;
    latch_c      = 1'b0;
    capture_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_c) begin
          dbus_req     = 1'b1;
          bus_c        = req_c;
          stallreq_mem = 1'b1;
          if (dbus_addr_ok) begin
            // Zero-latency completion is handled exactly like REQ.
            if (dbus_data_ok) begin
              capture_c = 1'b1;
              state_d   = S_DONE;
            end else begin
              state_d   = S_WAIT;
            end
          end else begin
            latch_c = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        dbus_req     = 1'b1;
        bus_c        = req_q;
        stallreq_mem = valid_c;
        if (dbus_addr_ok) begin
          if (dbus_data_ok) begin
            capture_c = ~flush;
            state_d   = flush ? S_IDLE : S_DONE;
          end else begin
            state_d   = flush ? S_DRAIN : S_WAIT;
          end
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stallreq_mem = valid_c;
        if (dbus_data_ok) begin
          capture_c = ~flush;
          state_d   = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: begin
        stallreq_mem = valid_c;
        if (dbus_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbus_we    = bus_c.we;
  assign dbus_be    = bus_c.be;
  assign dbus_addr  = ADDR_W'(bus_c.addr);
  assign dbus_wdata = DATA_W'(bus_c.wdata);

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed + randomized bench for mem_dbus_ctrl with a behavioural model of
// lane selection, extension and alignment.
module tb_mem_dbus_ctrl;
  import mem_dbus_ctrl_pkg::*;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst_n;
  logic        flush;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_wd, mem_din;
  logic [4:0]  mem_exccode;
  logic        dbus_req, dbus_we;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_addr, dbus_wdata;
  logic        dbus_addr_ok, dbus_data_ok;
  logic [31:0] dbus_rdata;
  logic [31:0] mem_rdata_o;
  logic [4:0]  mem_exccode_o;
  logic [31:0] mem_badvaddr;
  logic        stallreq_mem;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_rdata;
  logic [7:0]  ops [8];

  localparam logic [7:0] OP_NOP = 8'h00;

  mem_dbus_ctrl dut (
    .cpu_clk_50M  (cpu_clk_50M),
    .cpu_rst_n    (cpu_rst_n),
    .flush        (flush),
    .mem_aluop    (mem_aluop),
    .mem_wd       (mem_wd),
    .mem_din      (mem_din),
    .mem_exccode  (mem_exccode),
    .dbus_req     (dbus_req),
    .dbus_we      (dbus_we),
    .dbus_be      (dbus_be),
    .dbus_addr    (dbus_addr),
    .dbus_wdata   (dbus_wdata),
    .dbus_addr_ok (dbus_addr_ok),
    .dbus_data_ok (dbus_data_ok),
    .dbus_rdata   (dbus_rdata),
    .mem_rdata_o  (mem_rdata_o),
    .mem_exccode_o(mem_exccode_o),
    .mem_badvaddr (mem_badvaddr),
    .stallreq_mem (stallreq_mem)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int op_size(input logic [7:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    if (op == OP_LW || op == OP_SW) return 4;
    return 0;
  endfunction

  function automatic bit op_store(input logic [7:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic logic [3:0] ref_be(input logic [7:0] op, input logic [31:0] addr);
    int s = op_size(op);
    int off = int'(addr % 4);
    return 4'(((1 << s) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] din);
    int s = op_size(op);
    if (s == 1) return (din & 32'hFF) * 32'h0101_0101;
    if (s == 2) return (din & 32'hFFFF) * 32'h0001_0001;
    return din;
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int s = op_size(op);
    longint unsigned mask = (64'd1 << (8 * s)) - 1;
    longint unsigned v = (longint'(rd) >> (8 * (addr % 4))) & mask;
    if ((op == OP_LB || op == OP_LH) && ((v >> (8 * s - 1)) & 1) == 1) v = v | ~mask;
    return v[31:0];
  endfunction

  // Full handshake: addr_ok after `a` extra request cycles, data_ok `d` cycles later.
  task automatic access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] din,
                        input logic [31:0] rd, input int a, input int d);
    logic [31:0] exp_rd;
    exp_rd = op_store(op) ? model_rdata : ref_load(op, addr, rd);
    mem_aluop = op; mem_wd = addr; mem_din = din; dbus_rdata = rd;
    for (int c = 0; c < a + 1 + d; c++) begin
      dbus_addr_ok = (c == a);
      dbus_data_ok = (c == a + d);
      @(negedge cpu_clk_50M);
      if (c <= a) begin
        chk("req", 32'(dbus_req), 32'd1);
        chk("be", 32'(dbus_be), 32'(ref_be(op, addr)));
        chk("addr", dbus_addr, addr & ~32'd3);
        chk("we", 32'(dbus_we), 32'(op_store(op)));
        if (op_store(op)) chk("wdata", dbus_wdata, ref_wdata(op, din));
      end else begin
        chk("req_wait", 32'(dbus_req), 32'd0);
      end
      chk("stall_busy", 32'(stallreq_mem), 32'd1);
      @(posedge cpu_clk_50M); #1;
    end
    dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0;
    @(negedge cpu_clk_50M);
    chk("stall_done", 32'(stallreq_mem), 32'd0);
    chk("req_done", 32'(dbus_req), 32'd0);
    chk("rdata", mem_rdata_o, exp_rd);
    model_rdata = exp_rd;
    @(posedge cpu_clk_50M); #1;
    mem_aluop = OP_NOP;
  endtask

  task automatic misaligned(input logic [7:0] op, input logic [31:0] addr);
    mem_aluop = op; mem_wd = addr;
    @(negedge cpu_clk_50M);
    chk("mis_req", 32'(dbus_req), 32'd0);
    chk("mis_stall", 32'(stallreq_mem), 32'd0);
    chk("mis_exc", 32'(mem_exccode_o), op_store(op) ? 32'h05 : 32'h04);
    chk("mis_badva", mem_badvaddr, addr);
    @(posedge cpu_clk_50M); #1;
    mem_aluop = OP_NOP;
  endtask

  initial begin
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    cpu_rst_n = 1'b0; flush = 1'b0; mem_aluop = OP_LW; mem_wd = 32'h1000;
    mem_din = '0; mem_exccode = EXC_NONE; dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0;
    dbus_rdata = '0; model_rdata = '0;

    // Reset values, with a valid op already presented.
    #5;
    chk("rst_req", 32'(dbus_req), 32'd0);
    chk("rst_be", 32'(dbus_be), 32'd0);
    chk("rst_addr", dbus_addr, 32'd0);
    chk("rst_wdata", dbus_wdata, 32'd0);
    chk("rst_stall", 32'(stallreq_mem), 32'd0);
    chk("rst_rdata", mem_rdata_o, 32'd0);
    chk("rst_exc", 32'(mem_exccode_o), 32'(EXC_NONE));
    mem_aluop = OP_NOP;
    @(negedge cpu_clk_50M); cpu_rst_n = 1'b1;
    @(posedge cpu_clk_50M); #1;

    // Directed cases from the feature list.
    access(OP_LW, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 2, 1);
    access(OP_LB, 32'h0000_2003, 32'h0, 32'h8011_2233, 0, 1);
    access(OP_LBU, 32'h0000_2003, 32'h0, 32'h8011_2233, 1, 2);
    access(OP_SH, 32'h0000_3002, 32'h0000_ABCD, 32'h5555_5555, 0, 1);
    access(OP_LH, 32'h0000_3000, 32'h0, 32'h1234_F00D, 1, 0);
    misaligned(OP_LW, 32'h0000_4001);
    misaligned(OP_SW, 32'h0000_4001);
    misaligned(OP_LHU, 32'h0000_4003);

    // Upstream exception passes through, no access.
    mem_aluop = OP_LW; mem_wd = 32'h100; mem_exccode = 5'h0C;
    @(negedge cpu_clk_50M);
    chk("upx_req", 32'(dbus_req), 32'd0);
    chk("upx_exc", 32'(mem_exccode_o), 32'h0C);
    chk("upx_stall", 32'(stallreq_mem), 32'd0);
    @(posedge cpu_clk_50M); #1;
    mem_exccode = EXC_NONE; mem_aluop = OP_NOP;

    // Flush in REQ before addr_ok: request dropped.
    mem_aluop = OP_SW; mem_wd = 32'h40; mem_din = 32'h1;
    @(negedge cpu_clk_50M); chk("frq_req0", 32'(dbus_req), 32'd1);
    @(posedge cpu_clk_50M); #1; flush = 1'b1;
    @(negedge cpu_clk_50M); chk("frq_req1", 32'(dbus_req), 32'd1);
    chk("frq_stall", 32'(stallreq_mem), 32'd0);
    @(posedge cpu_clk_50M); #1; flush = 1'b0; mem_aluop = OP_NOP;
    @(negedge cpu_clk_50M); chk("frq_req2", 32'(dbus_req), 32'd0);
    @(posedge cpu_clk_50M); #1;

    // Flush in WAIT: drain the old response while the next LW stalls.
    mem_aluop = OP_LW; mem_wd = 32'h2000; dbus_addr_ok = 1'b1;
    @(negedge cpu_clk_50M); chk("fw_req", 32'(dbus_req), 32'd1);
    @(posedge cpu_clk_50M); #1; dbus_addr_ok = 1'b0; flush = 1'b1;
    @(negedge cpu_clk_50M); chk("fw_req_wait", 32'(dbus_req), 32'd0);
    @(posedge cpu_clk_50M); #1; flush = 1'b0; mem_wd = 32'h3008;
    for (int i = 0; i < 2; i++) begin
      @(negedge cpu_clk_50M);
      chk("drain_req", 32'(dbus_req), 32'd0);
      chk("drain_stall", 32'(stallreq_mem), 32'd1);
      @(posedge cpu_clk_50M); #1;
    end
    dbus_data_ok = 1'b1; dbus_rdata = 32'h1111_1111;
    @(negedge cpu_clk_50M);
    chk("drain_last_req", 32'(dbus_req), 32'd0);
    chk("drain_last_stall", 32'(stallreq_mem), 32'd1);
    @(posedge cpu_clk_50M); #1; dbus_data_ok = 1'b0;
    chk("drain_discard", mem_rdata_o, model_rdata);
    access(OP_LW, 32'h3008, 32'h0, 32'hCAFE_0001, 0, 1);

    // Reset while in WAIT: outputs drop without a clock edge.
    mem_aluop = OP_LW; mem_wd = 32'h5000; dbus_addr_ok = 1'b1;
    @(posedge cpu_clk_50M); #1; dbus_addr_ok = 1'b0;
    #3 cpu_rst_n = 1'b0;
    #1;
    chk("rw_req", 32'(dbus_req), 32'd0);
    chk("rw_stall", 32'(stallreq_mem), 32'd0);
    chk("rw_rdata", mem_rdata_o, 32'd0);
    model_rdata = '0; mem_aluop = OP_NOP;
    @(negedge cpu_clk_50M); cpu_rst_n = 1'b1;
    @(posedge cpu_clk_50M); #1;
    access(OP_LHU, 32'h5002, 32'h0, 32'h9ABC_0000, 0, 2);

    // Randomized accesses.
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  op;
      logic [31:0] addr;
      int a, d;
      op   = ops[$urandom_range(0, 7)];
      addr = $urandom;
      a    = $urandom_range(0, 2);
      d    = (a == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
      if (addr % op_size(op) != 0) misaligned(op, addr);
      else access(op, addr, $urandom, $urandom, a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
